// File: rtl/cfg_bank_pkg.sv
// Shared encodings for the config register bank: FSM states, arbiter grant IDs
// and the flat CFG_OUT slice offset helper.
package cfg_bank_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  function automatic int cfg_ofs(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cfg_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, zero latency;
// the requester not granted last wins a contention, and `last` moves only on a grant.
module cfg_rr_arb2
  import cfg_bank_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == GNT_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last <= GNT_B;
    end else if (gnt[GNT_A]) begin
      last <= GNT_A;
    end else if (gnt[GNT_B]) begin
      last <= GNT_B;
    end
  end

endmodule

// File: rtl/cfg_reg_bank_arb.sv
// Shadow/active config register bank: two arbitrated writers fill the shadow copy,
// COMMIT_REQ copies it to the active copy one cycle later; writers stall during a commit.
module cfg_reg_bank_arb
  import cfg_bank_pkg::*;
#(
  parameter int               NREGS = 8,
  parameter int               WIDTH = 32,
  parameter int               AW    = 3,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   A_VALID,
  output logic                   A_READY,
  input  logic [AW-1:0]          A_ADDR,
  input  logic [WIDTH-1:0]       A_DATA,
  input  logic                   B_VALID,
  output logic                   B_READY,
  input  logic [AW-1:0]          B_ADDR,
  input  logic [WIDTH-1:0]       B_DATA,
  input  logic                   COMMIT_REQ,
  output logic                   COMMIT_ACK,
  output logic                   DIRTY,
  output logic                   ERR,
  input  logic                   ERR_CLR,
  input  logic [AW-1:0]          SH_RD_ADDR,
  output logic [WIDTH-1:0]       SH_RD_DATA,
  output logic [NREGS*WIDTH-1:0] CFG_OUT
);

  state_t           state;
  state_t           state_nxt;
  logic             arb_en;
  logic [1:0]       gnt;
  logic             wr_en;
  logic             wr_hit;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] shadow [NREGS];
  logic [WIDTH-1:0] active [NREGS];

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      IDLE: begin
        if (COMMIT_REQ) begin
          state_nxt = COMMIT;
        end else begin
          arb_en = RST_N;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  cfg_rr_arb2 u_arb (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req    ({B_VALID, A_VALID}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  assign A_READY    = gnt[GNT_A];
  assign B_READY    = gnt[GNT_B];
  // Suppress the pulse when reset lands on the commit cycle: the copy is dropped too.
  assign COMMIT_ACK = (state == COMMIT) && RST_N;

  assign wr_en   = |gnt;
  assign wr_addr = gnt[GNT_B] ? B_ADDR : A_ADDR;
  assign wr_data = gnt[GNT_B] ? B_DATA : A_DATA;

  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_addr == AW'(i)) begin
        wr_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow[i] <= INIT;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_addr == AW'(i)) begin
          shadow[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        active[i] <= INIT;
      end
    end else if (state == COMMIT) begin
      for (int i = 0; i < NREGS; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DIRTY <= 1'b0;
    end else if (state == COMMIT) begin
      DIRTY <= 1'b0;
    end else if (wr_en && wr_hit) begin
      DIRTY <= 1'b1;
    end
  end

  // A new error beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ERR <= 1'b0;
    end else if (wr_en && !wr_hit) begin
      ERR <= 1'b1;
    end else if (ERR_CLR) begin
      ERR <= 1'b0;
    end
  end

  always_comb begin
    SH_RD_DATA = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (SH_RD_ADDR == AW'(i)) begin
        SH_RD_DATA = shadow[i];
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cfg_out
    assign CFG_OUT[cfg_ofs(g, WIDTH) +: WIDTH] = active[g];
  end

endmodule

// File: tb/tb_cfg_reg_bank_arb.sv
// Randomized bench: driver predicts each cycle from a behavioural model into a queue,
// a negedge monitor pops and compares handshakes, readback, CFG_OUT, DIRTY and ERR.
module tb_cfg_reg_bank_arb;

  localparam int               NREGS = 8;
  localparam int               WIDTH = 32;
  localparam int               AW    = 4;
  localparam logic [WIDTH-1:0] INIT  = 32'hA5A5_0001;
  localparam int               NCYC  = 4000;

  logic                   CLK;
  logic                   RST_N;
  logic                   A_VALID, A_READY, B_VALID, B_READY;
  logic [AW-1:0]          A_ADDR, B_ADDR, SH_RD_ADDR;
  logic [WIDTH-1:0]       A_DATA, B_DATA, SH_RD_DATA;
  logic                   COMMIT_REQ, COMMIT_ACK, DIRTY, ERR, ERR_CLR;
  logic [NREGS*WIDTH-1:0] CFG_OUT;

  cfg_reg_bank_arb #(.NREGS(NREGS), .WIDTH(WIDTH), .AW(AW), .INIT(INIT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
    .COMMIT_REQ(COMMIT_REQ), .COMMIT_ACK(COMMIT_ACK), .DIRTY(DIRTY), .ERR(ERR),
    .ERR_CLR(ERR_CLR), .SH_RD_ADDR(SH_RD_ADDR), .SH_RD_DATA(SH_RD_DATA), .CFG_OUT(CFG_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit                     chk;
    logic [2:0]             ev;    // {ack, b_ready, a_ready}
    logic [WIDTH-1:0]       sh;
    logic [NREGS*WIDTH-1:0] cfg;
    logic                   dirty;
    logic                   err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state (what the bank should hold right now)
  logic [WIDTH-1:0] m_sh  [NREGS];
  logic [WIDTH-1:0] m_act [NREGS];
  bit m_dirty, m_err, m_commit_now, m_last_b, m_known;

  task automatic chk(input string nm, input logic [NREGS*WIDTH-1:0] act,
                     input logic [NREGS*WIDTH-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          chk("handshake", {COMMIT_ACK, B_READY, A_READY}, e.ev);
          chk("sh_rd_data", SH_RD_DATA, e.sh);
          chk("cfg_out", CFG_OUT, e.cfg);
          chk("dirty", DIRTY, e.dirty);
          chk("err", ERR, e.err);
        end
      end
    end
  end

  // Driver + model
  initial begin
    bit               a_pend, b_pend, creq, rst, eclr, ga, gb, ack;
    logic [AW-1:0]    a_addr, b_addr, rd, w_addr;
    logic [WIDTH-1:0] a_data, b_data, w_data;
    exp_t             e;
    int               wait_cyc;

    a_pend = 0; b_pend = 0; creq = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    m_known = 0; m_dirty = 0; m_err = 0; m_commit_now = 0; m_last_b = 1;
    for (int i = 0; i < NREGS; i++) begin
      m_sh[i] = INIT; m_act[i] = INIT;
    end
    RST_N = 0; A_VALID = 0; B_VALID = 0; A_ADDR = '0; B_ADDR = '0;
    A_DATA = '0; B_DATA = '0; COMMIT_REQ = 0; ERR_CLR = 0; SH_RD_ADDR = '0;
    @(posedge CLK); #1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc < 2) rst = 1;
      else if (m_commit_now && $urandom_range(0, 4) == 0) rst = 1;
      else rst = ($urandom_range(0, 199) == 0);

      if (!a_pend && $urandom_range(0, 9) < 6) begin
        a_pend = 1;
        a_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(NREGS, 15))
                                             : AW'($urandom_range(0, NREGS-1));
        a_data = (a_addr < NREGS && $urandom_range(0, 3) == 0) ? m_sh[a_addr] : $urandom;
      end
      if (!b_pend && $urandom_range(0, 9) < 6) begin
        b_pend = 1;
        b_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(NREGS, 15))
                                             : AW'($urandom_range(0, NREGS-1));
        b_data = (b_addr < NREGS && $urandom_range(0, 3) == 0) ? m_sh[b_addr] : $urandom;
      end
      if (!creq && $urandom_range(0, 24) == 0) creq = 1;
      eclr = ($urandom_range(0, 9) == 0);
      rd   = AW'($urandom_range(0, 15));

      RST_N = !rst; A_VALID = a_pend; A_ADDR = a_addr; A_DATA = a_data;
      B_VALID = b_pend; B_ADDR = b_addr; B_DATA = b_data;
      COMMIT_REQ = creq; ERR_CLR = eclr; SH_RD_ADDR = rd;

      // Expected outputs for this cycle, from the model's current contents
      ga = 0; gb = 0; ack = 0;
      if (!rst) begin
        if (m_commit_now) ack = 1;
        else if (!creq) begin
          if (a_pend && b_pend) begin
            ga = m_last_b; gb = !m_last_b;
          end else begin
            ga = a_pend; gb = b_pend;
          end
        end
      end
      e.chk   = m_known;
      e.ev    = {ack, gb, ga};
      e.sh    = (rd < NREGS) ? m_sh[rd] : '0;
      for (int i = 0; i < NREGS; i++) e.cfg[i*WIDTH +: WIDTH] = m_act[i];
      e.dirty = m_dirty;
      e.err   = m_err;
      exp_q.push_back(e);

      // Model update at the clock edge
      if (rst) begin
        for (int i = 0; i < NREGS; i++) begin
          m_sh[i] = INIT; m_act[i] = INIT;
        end
        m_dirty = 0; m_err = 0; m_commit_now = 0; m_last_b = 1; m_known = 1;
      end else begin
        if (m_commit_now) begin
          for (int i = 0; i < NREGS; i++) m_act[i] = m_sh[i];
          m_dirty = 0; m_commit_now = 0; creq = 0;
        end else if (creq) begin
          m_commit_now = 1;
        end
        if (ga || gb) begin
          w_addr = ga ? a_addr : b_addr;
          w_data = ga ? a_data : b_data;
          if (w_addr < NREGS) begin
            m_sh[w_addr] = w_data; m_dirty = 1;
          end
          m_last_b = gb;
          if (ga) a_pend = 0; else b_pend = 0;
        end
        if ((ga || gb) && w_addr >= NREGS) m_err = 1;
        else if (eclr) m_err = 0;
      end

      @(posedge CLK); #1;
    end

    A_VALID = 0; B_VALID = 0; COMMIT_REQ = 0; ERR_CLR = 0;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(negedge CLK); #1;
      wait_cyc++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
